// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite master adaptor: FSM states, AXI
// response codes, request size encodings and width helpers.
package axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR_DATA,
        ST_RD_ADDR,
        ST_WAIT_B,
        ST_WAIT_R,
        ST_RESP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT = 3'b000;

    localparam int SIZE_1B = 0;
    localparam int SIZE_2B = 1;
    localparam int SIZE_4B = 2;
    localparam int SIZE_8B = 3;

    // log2 of the number of byte lanes in a data word
    function automatic int lg_bytes(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    // width of the log2(bytes) size field, wide enough to encode lg_bytes itself
    function automatic int size_width(input int data_width);
        return $clog2(lg_bytes(data_width) + 1);
    endfunction

    // number of write strobe bits
    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/axil_lane_steer.sv
// Byte-lane steering for the AXI4-Lite master: builds wstrb/wdata for a
// sized, possibly misaligned write and right-aligns/masks read data.
module axil_lane_steer
    import axil_pkg::*;
#(
    parameter int data_width_p = 32
) (
    input  logic [lg_bytes(data_width_p)-1:0]   offset,
    input  logic [size_width(data_width_p)-1:0] size,
    input  logic [data_width_p-1:0]             cmd_wdata,
    input  logic [data_width_p-1:0]             slave_rdata,
    output logic [strb_width(data_width_p)-1:0] lane_wstrb,
    output logic [data_width_p-1:0]             lane_wdata,
    output logic [data_width_p-1:0]             resp_rdata
);

    localparam int strb_w = strb_width(data_width_p);
    localparam int lg_w   = lg_bytes(data_width_p);

    int off;
    int nbytes;

    // Oversized requests collapse to a full word; derive active byte count.
    always_comb begin
        off    = int'(offset);
        nbytes = (int'(size) > lg_w) ? strb_w : (1 << int'(size));
    end

    // Strobes cover [off, off+nbytes) clipped at the word end; request bytes
    // repeat across lanes, phased so that lane `off` carries byte 0.
    always_comb begin
        lane_wstrb = '0;
        lane_wdata = '0;
        for (int i = 0; i < strb_w; i++) begin
            lane_wstrb[i]        = (i >= off) && (i < off + nbytes);
            lane_wdata[8*i +: 8] = cmd_wdata[8*((i - off) & (nbytes - 1)) +: 8];
        end
    end

    // Shift the addressed byte down to lane 0 and zero bytes past the size.
    always_comb begin
        resp_rdata = '0;
        for (int i = 0; i < strb_w; i++) begin
            if ((i < nbytes) && (i + off < strb_w))
                resp_rdata[8*i +: 8] = slave_rdata[8*((i + off) % strb_w) +: 8];
        end
    end

endmodule

// File: rtl/axil_master_adaptor.sv
// AXI4-Lite master adaptor: one outstanding cmd -> AXI-Lite transaction,
// result returned on resp. Optional response timeout with stray-response
// discard is enabled by defining AXIL_MASTER_TIMEOUT_EN.
module axil_master_adaptor
    import axil_pkg::*;
#(
    parameter int axil_data_width_p = 32,
    parameter int axil_addr_width_p = 32,
    parameter int timeout_cycles_p  = 1024
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic                                      cmd_v_i,
    output logic                                      cmd_ready_and_o,
    input  logic [axil_addr_width_p-1:0]              cmd_addr_i,
    input  logic                                      cmd_wr_en_i,
    input  logic [size_width(axil_data_width_p)-1:0]  cmd_data_size_i,
    input  logic [axil_data_width_p-1:0]              cmd_wdata_i,
    output logic                                      resp_v_o,
    input  logic                                      resp_ready_and_i,
    output logic [axil_data_width_p-1:0]              resp_rdata_o,
    output logic                                      resp_err_o,
    output logic [axil_addr_width_p-1:0]              m_axil_awaddr_o,
    output logic [2:0]                                m_axil_awprot_o,
    output logic                                      m_axil_awvalid_o,
    input  logic                                      m_axil_awready_i,
    output logic [axil_data_width_p-1:0]              m_axil_wdata_o,
    output logic [strb_width(axil_data_width_p)-1:0]  m_axil_wstrb_o,
    output logic                                      m_axil_wvalid_o,
    input  logic                                      m_axil_wready_i,
    input  logic [1:0]                                m_axil_bresp_i,
    input  logic                                      m_axil_bvalid_i,
    output logic                                      m_axil_bready_o,
    output logic [axil_addr_width_p-1:0]              m_axil_araddr_o,
    output logic [2:0]                                m_axil_arprot_o,
    output logic                                      m_axil_arvalid_o,
    input  logic                                      m_axil_arready_i,
    input  logic [axil_data_width_p-1:0]              m_axil_rdata_i,
    input  logic [1:0]                                m_axil_rresp_i,
    input  logic                                      m_axil_rvalid_i,
    output logic                                      m_axil_rready_o
);

    localparam int lg_lp   = lg_bytes(axil_data_width_p);
    localparam int size_lp = size_width(axil_data_width_p);

    state_e state_r, state_n;
    logic   awvalid_r, awvalid_n, wvalid_r, wvalid_n;
    logic   accept, waiting, tmo_hit, orphan, orphan_wr;

    logic [axil_addr_width_p-1:0] addr_r;
    logic [size_lp-1:0]           size_r;
    logic [axil_data_width_p-1:0] wdata_r, rdata_r, steered_rdata;
    logic                         err_r;

    assign cmd_ready_and_o = (state_r == ST_IDLE) && !orphan;
    assign accept          = cmd_v_i && cmd_ready_and_o;
    assign waiting         = (state_r == ST_WAIT_B) || (state_r == ST_WAIT_R);

    // State register plus the two independently retiring write-channel valids.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r   <= ST_IDLE;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
        end else begin
            state_r   <= state_n;
            awvalid_r <= awvalid_n;
            wvalid_r  <= wvalid_n;
        end
    end

    // Next-state logic; AW and W each drop on their own handshake.
    always_comb begin
        state_n   = state_r;
        awvalid_n = awvalid_r;
        wvalid_n  = wvalid_r;
        case (state_r)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_wr_en_i) begin
                        state_n   = ST_WR_ADDR_DATA;
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                    end else begin
                        state_n = ST_RD_ADDR;
                    end
                end
            end
            ST_WR_ADDR_DATA: begin
                if (m_axil_awready_i) awvalid_n = 1'b0;
                if (m_axil_wready_i)  wvalid_n  = 1'b0;
                if (!awvalid_n && !wvalid_n) state_n = ST_WAIT_B;
            end
            ST_RD_ADDR: begin
                if (m_axil_arready_i) state_n = ST_WAIT_R;
            end
            ST_WAIT_B: begin
                if (m_axil_bvalid_i || tmo_hit) state_n = ST_RESP;
            end
            ST_WAIT_R: begin
                if (m_axil_rvalid_i || tmo_hit) state_n = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready_and_i) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Request fields are latched on accept and held for the whole transaction.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            addr_r  <= cmd_addr_i;
            size_r  <= cmd_data_size_i;
            wdata_r <= cmd_wdata_i;
        end
    end

    // Capture the response; a timeout reports an error with zero data.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rdata_r <= '0;
            err_r   <= 1'b0;
        end else if (state_r == ST_WAIT_B && m_axil_bvalid_i) begin
            rdata_r <= '0;
            err_r   <= m_axil_bresp_i[1];
        end else if (state_r == ST_WAIT_R && m_axil_rvalid_i) begin
            rdata_r <= steered_rdata;
            err_r   <= m_axil_rresp_i[1];
        end else if (tmo_hit) begin
            rdata_r <= '0;
            err_r   <= 1'b1;
        end
    end

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int cnt_w = $clog2(timeout_cycles_p + 1);
    logic [cnt_w-1:0] cnt_r;
    logic             orphan_r, orphan_wr_r;

    // Wait counter runs only in WAIT_B/WAIT_R and restarts from zero on entry.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)      cnt_r <= '0;
        else if (waiting) cnt_r <= cnt_r + cnt_w'(1);
        else              cnt_r <= '0;
    end

    assign tmo_hit = waiting && (cnt_r == cnt_w'(timeout_cycles_p - 1))
                   && !(state_r == ST_WAIT_B ? m_axil_bvalid_i : m_axil_rvalid_i);

    // After a timeout, keep the abandoned channel's ready high until the late response is swallowed.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            orphan_r    <= 1'b0;
            orphan_wr_r <= 1'b0;
        end else if (tmo_hit) begin
            orphan_r    <= 1'b1;
            orphan_wr_r <= (state_r == ST_WAIT_B);
        end else if (orphan_r && (orphan_wr_r ? m_axil_bvalid_i : m_axil_rvalid_i)) begin
            orphan_r    <= 1'b0;
        end
    end

    assign orphan    = orphan_r;
    assign orphan_wr = orphan_wr_r;
`else
    assign tmo_hit   = 1'b0;
    assign orphan    = 1'b0;
    assign orphan_wr = 1'b0;
`endif

    axil_lane_steer #(
        .data_width_p (axil_data_width_p)
    ) u_steer (
        .offset      (addr_r[lg_lp-1:0]),
        .size        (size_r),
        .cmd_wdata   (wdata_r),
        .slave_rdata (m_axil_rdata_i),
        .lane_wstrb  (m_axil_wstrb_o),
        .lane_wdata  (m_axil_wdata_o),
        .resp_rdata  (steered_rdata)
    );

    assign m_axil_awaddr_o  = addr_r;
    assign m_axil_araddr_o  = addr_r;
    assign m_axil_awprot_o  = AXI_PROT;
    assign m_axil_arprot_o  = AXI_PROT;
    assign m_axil_awvalid_o = awvalid_r;
    assign m_axil_wvalid_o  = wvalid_r;
    assign m_axil_arvalid_o = (state_r == ST_RD_ADDR);
    assign m_axil_bready_o  = (state_r == ST_WAIT_B) || (orphan && orphan_wr);
    assign m_axil_rready_o  = (state_r == ST_WAIT_R) || (orphan && !orphan_wr);

    assign resp_v_o     = (state_r == ST_RESP);
    assign resp_rdata_o = rdata_r;
    assign resp_err_o   = err_r;

    logic unused_bits;
    assign unused_bits = ^{m_axil_bresp_i[0], m_axil_rresp_i[0], timeout_cycles_p};

endmodule

// File: tb/tb_axil_master_adaptor.sv
// Directed bench for axil_master_adaptor: table of single transactions
// against a zero-wait slave plus hand-written multi-cycle sequences.
// The timeout sequence is included when AXIL_MASTER_TIMEOUT_EN is defined.
module tb_axil_master_adaptor;

    localparam int D   = 32;
    localparam int A   = 32;
    localparam int TMO = 16;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          cmd_v_i, cmd_ready_and_o, cmd_wr_en_i;
    logic [A-1:0]  cmd_addr_i;
    logic [1:0]    cmd_data_size_i;
    logic [D-1:0]  cmd_wdata_i;
    logic          resp_v_o, resp_ready_and_i, resp_err_o;
    logic [D-1:0]  resp_rdata_o;
    logic [A-1:0]  awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [D-1:0]  wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;

    int n_cmp  = 0;
    int n_fail = 0;

    axil_master_adaptor #(
        .axil_data_width_p (D),
        .axil_addr_width_p (A),
        .timeout_cycles_p  (TMO)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .cmd_v_i          (cmd_v_i),
        .cmd_ready_and_o  (cmd_ready_and_o),
        .cmd_addr_i       (cmd_addr_i),
        .cmd_wr_en_i      (cmd_wr_en_i),
        .cmd_data_size_i  (cmd_data_size_i),
        .cmd_wdata_i      (cmd_wdata_i),
        .resp_v_o         (resp_v_o),
        .resp_ready_and_i (resp_ready_and_i),
        .resp_rdata_o     (resp_rdata_o),
        .resp_err_o       (resp_err_o),
        .m_axil_awaddr_o  (awaddr),
        .m_axil_awprot_o  (awprot),
        .m_axil_awvalid_o (awvalid),
        .m_axil_awready_i (awready),
        .m_axil_wdata_o   (wdata),
        .m_axil_wstrb_o   (wstrb),
        .m_axil_wvalid_o  (wvalid),
        .m_axil_wready_i  (wready),
        .m_axil_bresp_i   (bresp),
        .m_axil_bvalid_i  (bvalid),
        .m_axil_bready_o  (bready),
        .m_axil_araddr_o  (araddr),
        .m_axil_arprot_o  (arprot),
        .m_axil_arvalid_o (arvalid),
        .m_axil_arready_i (arready),
        .m_axil_rdata_i   (rdata),
        .m_axil_rresp_i   (rresp),
        .m_axil_rvalid_i  (rvalid),
        .m_axil_rready_o  (rready)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wd;
        logic [31:0] srdata;
        logic [1:0]  sresp;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] wd);
        cmd_v_i         = 1'b1;
        cmd_wr_en_i     = wr;
        cmd_addr_i      = addr;
        cmd_data_size_i = size;
        cmd_wdata_i     = wd;
    endtask

    // One transaction against an always-ready slave that answers the cycle after AW/W or AR.
    task automatic run_vec(input vec_t v);
        awready = 1'b1; wready = 1'b1; arready = 1'b1; resp_ready_and_i = 1'b1;
        issue(v.wr, v.addr, v.size, v.wd);
        chk("cmd_ready_idle", cmd_ready_and_o, 1);
        step();
        cmd_v_i = 1'b0;
        if (v.wr) begin
            chk("awvalid_c1", awvalid, 1);
            chk("wvalid_c1", wvalid, 1);
            chk("awaddr", awaddr, v.addr);
            chk("wstrb", wstrb, v.e_strb);
            chk("wdata", wdata, v.e_wdata);
            chk("awprot", awprot, 0);
        end else begin
            chk("arvalid_c1", arvalid, 1);
            chk("araddr", araddr, v.addr);
            chk("arprot", arprot, 0);
        end
        chk("cmd_ready_busy", cmd_ready_and_o, 0);
        step();
        chk("resp_v_c2", resp_v_o, 0);
        if (v.wr) begin
            chk("awvalid_c2", awvalid, 0);
            chk("wvalid_c2", wvalid, 0);
            chk("bready_c2", bready, 1);
            bvalid = 1'b1; bresp = v.sresp;
        end else begin
            chk("arvalid_c2", arvalid, 0);
            chk("rready_c2", rready, 1);
            rvalid = 1'b1; rresp = v.sresp; rdata = v.srdata;
        end
        step();
        bvalid = 1'b0; rvalid = 1'b0;
        chk("resp_v_c3", resp_v_o, 1);
        chk("resp_rdata", resp_rdata_o, v.e_rdata);
        chk("resp_err", resp_err_o, v.e_err);
        step();
        chk("resp_v_done", resp_v_o, 0);
        chk("cmd_ready_done", cmd_ready_and_o, 1);
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h10, 2'd2, 32'hDEADBEEF, 32'h0,        2'b00, 4'hF,    32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1] = '{1'b0, 32'h13, 2'd0, 32'h0,        32'hAABBCCDD, 2'b00, 4'h0,    32'h0,        32'h000000AA, 1'b0};
        vecs[2] = '{1'b1, 32'h02, 2'd1, 32'hFFFF1234, 32'h0,        2'b00, 4'b1100, 32'h12341234, 32'h0,        1'b0};
        vecs[3] = '{1'b1, 32'h01, 2'd0, 32'h0000005A, 32'h0,        2'b00, 4'b0010, 32'h5A5A5A5A, 32'h0,        1'b0};
        vecs[4] = '{1'b1, 32'h03, 2'd1, 32'h0000BEEF, 32'h0,        2'b00, 4'b1000, 32'hEFBEEFBE, 32'h0,        1'b0};
        vecs[5] = '{1'b1, 32'h20, 2'd3, 32'h01020304, 32'h0,        2'b11, 4'hF,    32'h01020304, 32'h0,        1'b1};
        vecs[6] = '{1'b0, 32'h22, 2'd1, 32'h0,        32'h11223344, 2'b01, 4'h0,    32'h0,        32'h00001122, 1'b0};
        vecs[7] = '{1'b0, 32'h41, 2'd2, 32'h0,        32'h11223344, 2'b00, 4'h0,    32'h0,        32'h00112233, 1'b0};
        vecs[8] = '{1'b0, 32'h30, 2'd3, 32'h0,        32'hCAFEF00D, 2'b11, 4'h0,    32'h0,        32'hCAFEF00D, 1'b1};
        vecs[9] = '{1'b0, 32'h05, 2'd0, 32'h0,        32'h11223344, 2'b00, 4'h0,    32'h0,        32'h00000033, 1'b0};

        reset_i = 1'b1;
        cmd_v_i = 1'b0; cmd_wr_en_i = 1'b0; cmd_addr_i = '0; cmd_data_size_i = '0; cmd_wdata_i = '0;
        resp_ready_and_i = 1'b0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rresp = 2'b00; rdata = '0;

        // reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_rready", rready, 0);
        chk("rst_resp_v", resp_v_o, 0);
        chk("rst_resp_err", resp_err_o, 0);
        chk("rst_resp_rdata", resp_rdata_o, 0);
        reset_i = 1'b0;
        step();
        chk("rst_cmd_ready", cmd_ready_and_o, 1);

        // table of single transactions
        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // write with awready delayed: W retires first, AW held for 5 cycles
        awready = 1'b0; wready = 1'b1; resp_ready_and_i = 1'b0;
        issue(1'b1, 32'h80, 2'd2, 32'h00C0FFEE);
        step();
        cmd_v_i = 1'b0;
        chk("slow_aw_c1_aw", awvalid, 1);
        chk("slow_aw_c1_w", wvalid, 1);
        for (int k = 2; k <= 5; k++) begin
            step();
            chk("slow_aw_hold", awvalid, 1);
            chk("slow_aw_wdrop", wvalid, 0);
            chk("slow_aw_bready", bready, 0);
        end
        awready = 1'b1;
        step();
        awready = 1'b0;
        chk("slow_aw_drop", awvalid, 0);
        chk("slow_aw_bready_wait", bready, 1);
        bvalid = 1'b1; bresp = 2'b00;
        step();
        bvalid = 1'b0;
        chk("slow_aw_resp_v", resp_v_o, 1);
        chk("slow_aw_err", resp_err_o, 0);
        chk("slow_aw_bready_resp", bready, 0);
        chk("slow_aw_no_reissue", awvalid, 0);
        resp_ready_and_i = 1'b1;
        step();
        chk("slow_aw_idle", cmd_ready_and_o, 1);

        // read with SLVERR, response held while the consumer stalls
        arready = 1'b1; resp_ready_and_i = 1'b0;
        issue(1'b0, 32'h100, 2'd2, 32'h0);
        step();
        cmd_v_i = 1'b0;
        step();
        rvalid = 1'b1; rresp = 2'b10; rdata = 32'h12345678;
        step();
        rvalid = 1'b0; rdata = 32'hFFFFFFFF;
        for (int k = 0; k < 4; k++) begin
            chk("stall_resp_v", resp_v_o, 1);
            chk("stall_rdata", resp_rdata_o, 32'h12345678);
            chk("stall_err", resp_err_o, 1);
            chk("stall_cmd_ready", cmd_ready_and_o, 0);
            chk("stall_rready", rready, 0);
            if (k < 3) step();
        end
        resp_ready_and_i = 1'b1;
        step();
        chk("stall_release", resp_v_o, 0);
        chk("stall_cmd_ready_after", cmd_ready_and_o, 1);

        // asynchronous reset while waiting for R
        issue(1'b0, 32'h200, 2'd2, 32'h0);
        step();
        cmd_v_i = 1'b0;
        step();
        chk("arst_in_wait_r", rready, 1);
        #2;
        reset_i = 1'b1;
        #1;
        chk("arst_rready", rready, 0);
        chk("arst_arvalid", arvalid, 0);
        chk("arst_awvalid", awvalid, 0);
        chk("arst_wvalid", wvalid, 0);
        chk("arst_bready", bready, 0);
        chk("arst_resp_v", resp_v_o, 0);
        step();
        reset_i = 1'b0;
        step();
        chk("arst_cmd_ready", cmd_ready_and_o, 1);
        run_vec(vecs[1]);

`ifdef AXIL_MASTER_TIMEOUT_EN
        // missing B: timeout, then the late B is swallowed before new commands
        awready = 1'b1; wready = 1'b1; resp_ready_and_i = 1'b0;
        issue(1'b1, 32'h40, 2'd2, 32'h55AA55AA);
        step();
        cmd_v_i = 1'b0;
        step();
        for (int k = 2; k < 2 + TMO; k++) begin
            chk("tmo_wait_resp_v", resp_v_o, 0);
            step();
        end
        chk("tmo_resp_v", resp_v_o, 1);
        chk("tmo_err", resp_err_o, 1);
        chk("tmo_rdata", resp_rdata_o, 0);
        resp_ready_and_i = 1'b1;
        step();
        chk("tmo_cmd_blocked", cmd_ready_and_o, 0);
        chk("tmo_orphan_bready", bready, 1);
        step();
        chk("tmo_cmd_blocked2", cmd_ready_and_o, 0);
        bvalid = 1'b1;
        step();
        bvalid = 1'b0;
        chk("tmo_cmd_free", cmd_ready_and_o, 1);
        chk("tmo_bready_off", bready, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
